// File: rtl/data_path_pkg.sv
// Shared types and constants for the data_path five-stage ARM32-subset core.
package data_path_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {KIND_NONE, KIND_DP, KIND_MEM, KIND_BR} kind_e;
    typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic        fwd;
        kind_e       kind;
        logic [3:0]  cond;
        logic [3:0]  op;
        logic        set_flags;
        logic        use_imm;
        logic        load;
        logic        up;
        logic        wr_en;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] rn_val;
        logic [31:0] rm_val;
        logic [31:0] rd_val;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic        wr_en;
        logic        load;
        logic        store;
        logic [3:0]  rd;
        logic [31:0] result;
        logic [31:0] st_data;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic        wr_en;
        logic [3:0]  rd;
        logic [31:0] result;
    } mem_wb_t;

    function automatic logic cond_pass(input logic [3:0] cond, input logic z);
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd_mux(input fwd_sel_e sel, input logic [31:0] reg_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        case (sel)
            FWD_MEM: return mem_val;
            FWD_WB:  return wb_val;
            default: return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/data_path_hazard_unit.sv
// Stall, flush and forward-select generation; forwarding exists only with
// DATA_PATH_FWD_UNIT_EN defined, otherwise every RAW hazard stalls in ID.
module data_path_hazard_unit import data_path_pkg::*; (
    input  logic       fwd_en,
    input  logic       id_valid,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic [3:0] id_rd,
    input  logic       id_use_rn,
    input  logic       id_use_rm,
    input  logic       id_use_rd,
    input  logic       ex_valid,
    input  logic       ex_wr,
    input  logic       ex_load,
    input  logic       ex_fwd,
    input  logic [3:0] ex_rn,
    input  logic [3:0] ex_rm,
    input  logic [3:0] ex_rd,
    input  logic       mem_valid,
    input  logic       mem_wr,
    input  logic       mem_load,
    input  logic [3:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_wr,
    input  logic [3:0] wb_rd,
    input  logic       branch_taken,
    output logic       fwd_on,
    output logic       stall,
    output logic       flush,
    output fwd_sel_e   fwd_a,
    output fwd_sel_e   fwd_b,
    output fwd_sel_e   fwd_s
);

    logic raw_ex_s;
    logic raw_mem_s;

    function automatic logic src_hit(input logic use_r, input logic [3:0] src,
                                     input logic v, input logic w, input logic [3:0] dst);
        return use_r & v & w & (src == dst);
    endfunction

    // EX/MEM is only a forward source for ALU results; loads come from MEM/WB.
    function automatic fwd_sel_e pick(input logic [3:0] src);
        if (ex_fwd && mem_valid && mem_wr && !mem_load && (mem_rd == src)) begin
            return FWD_MEM;
        end else if (ex_fwd && wb_valid && wb_wr && (wb_rd == src)) begin
            return FWD_WB;
        end else begin
            return FWD_NONE;
        end
    endfunction

    // Hazard detection in ID and operand source selection in EX
    always_comb begin
        raw_ex_s  = src_hit(id_use_rn, id_rn, ex_valid, ex_wr, ex_rd)
                  | src_hit(id_use_rm, id_rm, ex_valid, ex_wr, ex_rd)
                  | src_hit(id_use_rd, id_rd, ex_valid, ex_wr, ex_rd);
        raw_mem_s = src_hit(id_use_rn, id_rn, mem_valid, mem_wr, mem_rd)
                  | src_hit(id_use_rm, id_rm, mem_valid, mem_wr, mem_rd)
                  | src_hit(id_use_rd, id_rd, mem_valid, mem_wr, mem_rd);
`ifdef DATA_PATH_FWD_UNIT_EN
        fwd_on = fwd_en;
        fwd_a  = pick(ex_rn);
        fwd_b  = pick(ex_rm);
        fwd_s  = pick(ex_rd);
`else
        fwd_on = 1'b0 & fwd_en;
        fwd_a  = FWD_NONE;
        fwd_b  = FWD_NONE;
        fwd_s  = FWD_NONE;
`endif
        flush = branch_taken;
        if (fwd_on) begin
            stall = id_valid & raw_ex_s & ex_load & ~branch_taken;
        end else begin
            stall = id_valid & (raw_ex_s | raw_mem_s) & ~branch_taken;
        end
    end

endmodule

// File: rtl/data_path.sv
// Five-stage in-order ARM32-subset core with internal ROM/RAM.
// Build option: DATA_PATH_FWD_UNIT_EN enables the forwarding unit (selected by FWRD_EN).
module data_path import data_path_pkg::*; #(
    parameter int    IMEM_WORDS = 256,
    parameter int    DMEM_WORDS = 256,
    parameter string INIT_FILE  = "program.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FWRD_EN,
    output logic [31:0] inst_count,
    output logic        stop
);

    logic [31:0] imem_r [IMEM_WORDS];
    logic [31:0] dmem_r [DMEM_WORDS];
    logic [31:0] rf_r   [16];

    logic [31:0] pc_r;
    if_id_t      ifid_r;
    id_ex_t      idex_r, idex_next_s;
    ex_mem_t     exmem_r, exmem_next_s;
    mem_wb_t     memwb_r, memwb_next_s;
    logic [1:0]  flags_r;
    logic [31:0] count_r;
    logic        stop_r;

    logic        use_rn_s, use_rm_s, use_rd_s;
    logic        fwd_on_s, stall_s, flush_s, freeze_s, wb_we_s;
    fwd_sel_e    fwd_a_s, fwd_b_s, fwd_s_s;
    logic [31:0] op_a_s, op_b_s, st_data_s, alu_s, target_s;
    logic        cond_ok_s, exec_s, branch_taken_s;

    assign wb_we_s  = memwb_r.valid & memwb_r.wr_en & ~memwb_r.halt;
    assign freeze_s = (ifid_r.valid & (ifid_r.instr == HALT_WORD)) | (idex_r.valid & idex_r.halt)
                    | (exmem_r.valid & exmem_r.halt) | (memwb_r.valid & memwb_r.halt) | stop_r;

    // ID: decode and register read (write-back value bypassed into the read)
    always_comb begin
        idex_next_s        = '0;
        use_rn_s           = 1'b0;
        use_rm_s           = 1'b0;
        use_rd_s           = 1'b0;
        idex_next_s.valid  = ifid_r.valid;
        idex_next_s.fwd    = fwd_on_s;
        idex_next_s.pc     = ifid_r.pc;
        idex_next_s.cond   = ifid_r.instr[31:28];
        idex_next_s.rn     = ifid_r.instr[19:16];
        idex_next_s.rd     = ifid_r.instr[15:12];
        idex_next_s.rm     = ifid_r.instr[3:0];
        if (ifid_r.instr == HALT_WORD) begin
            idex_next_s.halt = 1'b1;
        end else if (ifid_r.instr[27:26] == 2'b00) begin
            idex_next_s.kind    = KIND_DP;
            idex_next_s.op      = ifid_r.instr[24:21];
            idex_next_s.use_imm = ifid_r.instr[25];
            idex_next_s.imm     = {24'd0, ifid_r.instr[7:0]};
            use_rn_s            = (ifid_r.instr[24:21] != OP_MOV);
            use_rm_s            = ~ifid_r.instr[25];
            case (ifid_r.instr[24:21])
                OP_AND, OP_SUB, OP_ADD, OP_ORR, OP_MOV: begin
                    idex_next_s.wr_en     = 1'b1;
                    idex_next_s.set_flags = ifid_r.instr[20];
                end
                OP_CMP:  idex_next_s.set_flags = 1'b1;
                default: idex_next_s.wr_en     = 1'b0;
            endcase
        end else if (ifid_r.instr[27:26] == 2'b01) begin
            idex_next_s.kind    = KIND_MEM;
            idex_next_s.load    = ifid_r.instr[20];
            idex_next_s.up      = ifid_r.instr[23];
            idex_next_s.use_imm = 1'b1;
            idex_next_s.wr_en   = ifid_r.instr[20];
            idex_next_s.imm     = {20'd0, ifid_r.instr[11:0]};
            use_rn_s            = 1'b1;
            use_rd_s            = ~ifid_r.instr[20];
        end else if (ifid_r.instr[27:25] == 3'b101) begin
            idex_next_s.kind = KIND_BR;
            idex_next_s.imm  = {{6{ifid_r.instr[23]}}, ifid_r.instr[23:0], 2'b00};
        end else begin
            idex_next_s.kind = KIND_NONE;
        end
        idex_next_s.rn_val = (wb_we_s && memwb_r.rd == idex_next_s.rn) ? memwb_r.result : rf_r[idex_next_s.rn];
        idex_next_s.rm_val = (wb_we_s && memwb_r.rd == idex_next_s.rm) ? memwb_r.result : rf_r[idex_next_s.rm];
        idex_next_s.rd_val = (wb_we_s && memwb_r.rd == idex_next_s.rd) ? memwb_r.result : rf_r[idex_next_s.rd];
    end

    data_path_hazard_unit u_hazard (
        .fwd_en       (FWRD_EN),
        .id_valid     (ifid_r.valid),
        .id_rn        (idex_next_s.rn),
        .id_rm        (idex_next_s.rm),
        .id_rd        (idex_next_s.rd),
        .id_use_rn    (use_rn_s),
        .id_use_rm    (use_rm_s),
        .id_use_rd    (use_rd_s),
        .ex_valid     (idex_r.valid),
        .ex_wr        (idex_r.wr_en),
        .ex_load      (idex_r.load),
        .ex_fwd       (idex_r.fwd),
        .ex_rn        (idex_r.rn),
        .ex_rm        (idex_r.rm),
        .ex_rd        (idex_r.rd),
        .mem_valid    (exmem_r.valid),
        .mem_wr       (exmem_r.wr_en),
        .mem_load     (exmem_r.load),
        .mem_rd       (exmem_r.rd),
        .wb_valid     (memwb_r.valid),
        .wb_wr        (memwb_r.wr_en),
        .wb_rd        (memwb_r.rd),
        .branch_taken (branch_taken_s),
        .fwd_on       (fwd_on_s),
        .stall        (stall_s),
        .flush        (flush_s),
        .fwd_a        (fwd_a_s),
        .fwd_b        (fwd_b_s),
        .fwd_s        (fwd_s_s)
    );

    // EX: operand select, condition check, ALU, address and branch target
    always_comb begin
        op_a_s         = fwd_mux(fwd_a_s, idex_r.rn_val, exmem_r.result, memwb_r.result);
        st_data_s      = fwd_mux(fwd_s_s, idex_r.rd_val, exmem_r.result, memwb_r.result);
        op_b_s         = idex_r.use_imm ? idex_r.imm
                                        : fwd_mux(fwd_b_s, idex_r.rm_val, exmem_r.result, memwb_r.result);
        cond_ok_s      = cond_pass(idex_r.cond, flags_r[0]);
        exec_s         = idex_r.valid & (idex_r.halt | cond_ok_s);
        branch_taken_s = idex_r.valid & ~idex_r.halt & (idex_r.kind == KIND_BR) & cond_ok_s;
        target_s       = idex_r.pc + 32'd8 + idex_r.imm;
        case (idex_r.op)
            OP_AND:         alu_s = op_a_s & op_b_s;
            OP_SUB, OP_CMP: alu_s = op_a_s - op_b_s;
            OP_ADD:         alu_s = op_a_s + op_b_s;
            OP_ORR:         alu_s = op_a_s | op_b_s;
            OP_MOV:         alu_s = op_b_s;
            default:        alu_s = 32'd0;
        endcase
        exmem_next_s         = '0;
        exmem_next_s.valid   = exec_s;
        exmem_next_s.halt    = idex_r.halt;
        exmem_next_s.wr_en   = idex_r.wr_en;
        exmem_next_s.rd      = idex_r.rd;
        exmem_next_s.st_data = st_data_s;
        if (idex_r.kind == KIND_MEM) begin
            exmem_next_s.load   = idex_r.load;
            exmem_next_s.store  = ~idex_r.load;
            exmem_next_s.result = idex_r.up ? (op_a_s + idex_r.imm) : (op_a_s - idex_r.imm);
        end else begin
            exmem_next_s.result = alu_s;
        end
    end

    // MEM: combinational data RAM read for loads
    always_comb begin
        memwb_next_s        = '0;
        memwb_next_s.valid  = exmem_r.valid;
        memwb_next_s.halt   = exmem_r.halt;
        memwb_next_s.wr_en  = exmem_r.wr_en;
        memwb_next_s.rd     = exmem_r.rd;
        if (exmem_r.load) begin
            memwb_next_s.result = dmem_r[exmem_r.result[9:2]];
        end else begin
            memwb_next_s.result = exmem_r.result;
        end
    end

    // Fetch and pipeline register advance; flush beats stall, stall beats halt freeze
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r    <= 32'd0;
            ifid_r  <= '0;
            idex_r  <= '0;
            exmem_r <= '0;
            memwb_r <= '0;
        end else begin
            if (flush_s) begin
                pc_r   <= target_s;
                ifid_r <= '0;
            end else if (stall_s) begin
                ifid_r <= ifid_r;
            end else if (freeze_s) begin
                ifid_r <= '0;
            end else begin
                pc_r   <= pc_r + 32'd4;
                ifid_r <= '{valid: 1'b1, pc: pc_r, instr: imem_r[pc_r[9:2]]};
            end
            idex_r  <= (flush_s || stall_s) ? id_ex_t'('0) : idex_next_s;
            exmem_r <= exmem_next_s;
            memwb_r <= memwb_next_s;
        end
    end

    // Flags (written by EX), retire counter and sticky halt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_r <= 2'b00;
            count_r <= 32'd0;
            stop_r  <= 1'b0;
        end else begin
            if (exec_s && idex_r.set_flags) begin
                flags_r <= {alu_s[31], (alu_s == 32'd0)};
            end
            if (memwb_r.valid && !memwb_r.halt) begin
                count_r <= count_r + 32'd1;
            end
            if (memwb_r.valid && memwb_r.halt) begin
                stop_r <= 1'b1;
            end
        end
    end

    // Register file write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (wb_we_s) begin
            rf_r[memwb_r.rd] <= memwb_r.result;
        end
    end

    // Data RAM store; contents survive reset
    always_ff @(posedge clk) begin
        if (exmem_r.valid && exmem_r.store) begin
            dmem_r[exmem_r.result[9:2]] <= exmem_r.st_data;
        end
    end

    assign inst_count = count_r;
    assign stop       = stop_r;

endmodule

// File: tb/tb_data_path.sv
// Directed-program bench for data_path; programs are placed in the ROM by hierarchy.
module tb_data_path;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwrd_en;
    logic [31:0] inst_count;
    logic        stop;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;
    int first_ret;

`ifdef DATA_PATH_FWD_UNIT_EN
    localparam int CYC_A_FWD = 9;
    localparam int CYC_B_FWD = 12;
    localparam int CYC_C_FWD = 11;
`else
    localparam int CYC_A_FWD = 13;
    localparam int CYC_B_FWD = 17;
    localparam int CYC_C_FWD = 13;
`endif

    logic [31:0] prog_a [$];
    logic [31:0] prog_b [$];
    logic [31:0] prog_c [$];

    always #5 clk = ~clk;

    data_path #(.INIT_FILE("")) dut (
        .clk        (clk),
        .rst        (rst),
        .FWRD_EN    (fwrd_en),
        .inst_count (inst_count),
        .stop       (stop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_prog(input logic [31:0] prog [$]);
        for (int i = 0; i < 256; i++) begin
            dut.imem_r[i] = (i < prog.size()) ? prog[i] : 32'h0000_0000;
        end
    endtask

    // Reset, release on a falling edge, then count rising edges until stop
    task automatic run(input logic fe, output int cycles, output int first);
        rst     = 1'b0;
        fwrd_en = fe;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        cycles = 0;
        first  = 0;
        while (!stop && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (first == 0 && inst_count != 32'd0) first = cycles;
        end
        if (!stop) check("stop_timeout", {31'd0, stop}, 32'd1);
    endtask

    initial begin
        prog_a = '{32'hE3A0_1005, 32'hE3A0_2007, 32'hE081_3002, 32'hE580_3000, 32'hFFFF_FFFF};
        prog_b = '{32'hE3A0_1005, 32'hE3A0_2007, 32'hE081_3002, 32'hE580_3000,
                   32'hE590_4000, 32'hE284_5001, 32'hFFFF_FFFF};
        prog_c = '{32'hE3A0_1005, 32'hE351_0005, 32'h0A00_0000, 32'hE3A0_6001,
                   32'hE3A0_7002, 32'hFFFF_FFFF};

        rst     = 1'b0;
        fwrd_en = 1'b1;
        #1;
        check("reset_count", inst_count, 32'd0);
        check("reset_stop", {31'd0, stop}, 32'd0);

        // Forwarding on
        load_prog(prog_a);
        run(1'b1, cyc, first_ret);
        check("a_fwd_first_retire", first_ret, 32'd5);
        check("a_fwd_cycles", cyc, CYC_A_FWD);
        check("a_fwd_r1", dut.rf_r[1], 32'd5);
        check("a_fwd_r2", dut.rf_r[2], 32'd7);
        check("a_fwd_r3", dut.rf_r[3], 32'd12);
        check("a_fwd_dmem0", dut.dmem_r[0], 32'd12);
        check("a_fwd_count", inst_count, 32'd4);
        check("a_fwd_stop", {31'd0, stop}, 32'd1);

        // Forwarding off
        run(1'b0, cyc, first_ret);
        check("a_nofwd_first_retire", first_ret, 32'd5);
        check("a_nofwd_cycles", cyc, 32'd13);
        check("a_nofwd_r3", dut.rf_r[3], 32'd12);
        check("a_nofwd_dmem0", dut.dmem_r[0], 32'd12);
        check("a_nofwd_count", inst_count, 32'd4);

        // Load-use
        load_prog(prog_b);
        run(1'b1, cyc, first_ret);
        check("b_fwd_cycles", cyc, CYC_B_FWD);
        check("b_fwd_r4", dut.rf_r[4], 32'd12);
        check("b_fwd_r5", dut.rf_r[5], 32'd13);
        check("b_fwd_count", inst_count, 32'd6);
        run(1'b0, cyc, first_ret);
        check("b_nofwd_cycles", cyc, 32'd17);
        check("b_nofwd_r5", dut.rf_r[5], 32'd13);

        // Taken branch over MOV R6
        load_prog(prog_c);
        run(1'b1, cyc, first_ret);
        check("c_cycles", cyc, CYC_C_FWD);
        check("c_r1", dut.rf_r[1], 32'd5);
        check("c_r6", dut.rf_r[6], 32'd0);
        check("c_r7", dut.rf_r[7], 32'd2);
        check("c_count", inst_count, 32'd4);

        // Reset mid-run
        load_prog(prog_a);
        rst     = 1'b0;
        fwrd_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid_count_before", inst_count, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("mid_count_reset", inst_count, 32'd0);
        check("mid_stop_reset", {31'd0, stop}, 32'd0);
        check("mid_r1_reset", dut.rf_r[1], 32'd0);
        run(1'b1, cyc, first_ret);
        check("mid_rerun_cycles", cyc, CYC_A_FWD);
        check("mid_rerun_r3", dut.rf_r[3], 32'd12);
        check("mid_rerun_count", inst_count, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
